charram_dram_ctrl: RTL and testbench

// Controller side of the 4416-type char-RAM DRAM: arbitrates a CPU port and a video-fetch

---
 rtl/charram_dram_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_charram_dram_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/charram_dram_ctrl.sv
// Char-RAM DRAM controller: arbitrates a CPU port and a video-fetch port onto one
// 16Kx4 plane, sequencing row/column address, RAS/CAS and write/read strobes,
// and capturing read data for the port that owns the access.
module charram_dram_ctrl #(
  parameter int PRE_CYCLES = 1  // precharge cycles after every access, 1..7
) (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WR,
  input  logic [13:0] i_CPU_ADDR,
  input  logic [3:0]  i_CPU_DIN,
  output logic        o_CPU_ACK,
  output logic [3:0]  o_CPU_DOUT,
  input  logic        i_VID_REQ,
  input  logic [13:0] i_VID_ADDR,
  output logic        o_VID_VALID,
  output logic [3:0]  o_VID_DOUT,
  output logic [7:0]  o_DRAM_ADDR,
  output logic [3:0]  o_DRAM_DIN,
  input  logic [3:0]  i_DRAM_DOUT,
  output logic        o_RAS_n,
  output logic        o_CAS_n,
  output logic        o_WR_n,
  output logic        o_RD_n,
  output logic        o_BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_ACC, S_DATA, S_PRE
  } state_t;

  localparam logic [2:0] PRE_LAST = 3'(PRE_CYCLES - 1);

  state_t      state, state_nx;
  logic [2:0]  pre_cnt, pre_cnt_nx;

  // Access context latched at grant; inputs are ignored for the rest of the access.
  logic [13:0] addr_q, addr_nx;
  logic        wr_q, wr_nx;
  logic [3:0]  din_q, din_nx;
  logic        vid_q, vid_nx;

  // Next values of the registered outputs.
  logic        ras_n_nx, cas_n_nx, wr_n_nx, rd_n_nx;
  logic        ack_nx, valid_nx, busy_nx;
  logic [7:0]  dram_addr_nx;
  logic [3:0]  dram_din_nx, cpu_dout_nx, vid_dout_nx;

  // Next-state, grant and Moore output decode (outputs follow the next state so they
  // leave the flops aligned with the state itself).
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nx     = state;
    pre_cnt_nx   = pre_cnt;
    addr_nx      = addr_q;
    wr_nx        = wr_q;
    din_nx       = din_q;
    vid_nx       = vid_q;
    ras_n_nx     = 1'b1;
    cas_n_nx     = 1'b1;
    wr_n_nx      = 1'b1;
    rd_n_nx      = 1'b1;
    ack_nx       = 1'b0;
    valid_nx     = 1'b0;
    dram_addr_nx = o_DRAM_ADDR;
    dram_din_nx  = o_DRAM_DIN;
    cpu_dout_nx  = o_CPU_DOUT;
    vid_dout_nx  = o_VID_DOUT;

    case (state)
      S_IDLE: begin
        // Fixed priority: video fetch wins over the CPU.
        if (i_VID_REQ) begin
          state_nx = S_ROW;
          vid_nx   = 1'b1;
          wr_nx    = 1'b0;
          addr_nx  = i_VID_ADDR;
          din_nx   = 4'h0;
        end else if (i_CPU_REQ) begin
          state_nx = S_ROW;
          vid_nx   = 1'b0;
          wr_nx    = i_CPU_WR;
          addr_nx  = i_CPU_ADDR;
          din_nx   = i_CPU_DIN;
        end
      end
      S_ROW: state_nx = S_COL;
      S_COL: state_nx = S_ACC;
      S_ACC: state_nx = S_DATA;
      S_DATA: begin
        state_nx   = S_PRE;
        pre_cnt_nx = 3'd0;
        ack_nx     = ~vid_q;
        valid_nx   = vid_q;
        if (!wr_q) begin
          if (vid_q) vid_dout_nx = i_DRAM_DOUT;
          else       cpu_dout_nx = i_DRAM_DOUT;
        end
      end
      S_PRE: begin
        if (pre_cnt == PRE_LAST) state_nx   = S_IDLE;
        else                     pre_cnt_nx = pre_cnt + 3'd1;
      end
      default: state_nx = S_IDLE;
    endcase

    case (state_nx)
      S_ROW: begin
        ras_n_nx     = 1'b0;
        dram_addr_nx = addr_nx[7:0];
      end
      S_COL: begin
        ras_n_nx     = 1'b0;
        cas_n_nx     = 1'b0;
        dram_addr_nx = {1'b0, addr_nx[13:8], 1'b0};
      end
      S_ACC: begin
        ras_n_nx     = 1'b0;
        cas_n_nx     = 1'b0;
        dram_addr_nx = {1'b0, addr_nx[13:8], 1'b0};
        dram_din_nx  = din_nx;
        wr_n_nx      = ~wr_nx;
        rd_n_nx      = wr_nx;
      end
      S_DATA: begin
        ras_n_nx     = 1'b0;
        cas_n_nx     = 1'b0;
        dram_addr_nx = {1'b0, addr_nx[13:8], 1'b0};
      end
      default: ;
    endcase

    busy_nx = (state_nx != S_IDLE);
  end

  // State, access context and output registers; reset aborts any access immediately.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the values from before this edge, independent of statement order.
      state       <= S_IDLE;
      pre_cnt     <= 3'd0;
      addr_q      <= 14'h0;
      wr_q        <= 1'b0;
      din_q       <= 4'h0;
      vid_q       <= 1'b0;
      o_RAS_n     <= 1'b1;
      o_CAS_n     <= 1'b1;
      o_WR_n      <= 1'b1;
      o_RD_n      <= 1'b1;
      o_CPU_ACK   <= 1'b0;
      o_VID_VALID <= 1'b0;
      o_BUSY      <= 1'b0;
      o_DRAM_ADDR <= 8'h0;
      o_DRAM_DIN  <= 4'h0;
      o_CPU_DOUT  <= 4'h0;
      o_VID_DOUT  <= 4'h0;
    end else begin
      state       <= state_nx;
      pre_cnt     <= pre_cnt_nx;
      addr_q      <= addr_nx;
      wr_q        <= wr_nx;
      din_q       <= din_nx;
      vid_q       <= vid_nx;
      o_RAS_n     <= ras_n_nx;
      o_CAS_n     <= cas_n_nx;
      o_WR_n      <= wr_n_nx;
      o_RD_n      <= rd_n_nx;
      o_CPU_ACK   <= ack_nx;
      o_VID_VALID <= valid_nx;
      o_BUSY      <= busy_nx;
      o_DRAM_ADDR <= dram_addr_nx;
      o_DRAM_DIN  <= dram_din_nx;
      o_CPU_DOUT  <= cpu_dout_nx;
      o_VID_DOUT  <= vid_dout_nx;
    end
  end

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Bench for charram_dram_ctrl: a cycle-count transaction model predicts every output
// each cycle, a strobe-level 4416 model answers the DRAM bus, and directed scenarios
// pin timing and data with literal expectations.
module tb_charram_dram_ctrl;

  localparam int PRE = 1;

  logic        clk, rst;
  logic        cpu_req, cpu_wr, cpu_ack, vid_req, vid_valid;
  logic [13:0] cpu_addr, vid_addr;
  logic [3:0]  cpu_din, cpu_dout, vid_dout, dram_din, dram_dout;
  logic [7:0]  dram_addr;
  logic        ras_n, cas_n, wr_n, rd_n, busy;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  charram_dram_ctrl #(.PRE_CYCLES(PRE)) dut (
    .i_MCLK(clk), .i_RST(rst),
    .i_CPU_REQ(cpu_req), .i_CPU_WR(cpu_wr), .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
    .o_CPU_ACK(cpu_ack), .o_CPU_DOUT(cpu_dout),
    .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr), .o_VID_VALID(vid_valid), .o_VID_DOUT(vid_dout),
    .o_DRAM_ADDR(dram_addr), .o_DRAM_DIN(dram_din), .i_DRAM_DOUT(dram_dout),
    .o_RAS_n(ras_n), .o_CAS_n(cas_n), .o_WR_n(wr_n), .o_RD_n(rd_n), .o_BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Initial memory contents, shared by the DRAM model and the golden model.
  function automatic logic [3:0] init_val(input logic [13:0] a);
    return a[3:0] ^ a[11:8];
  endfunction

  logic [3:0] dram [0:16383];
  logic [3:0] gold [0:16383];

  // 4416 model: row latched on RAS, column on CAS; read data registered at the edge
  // that sees RD low; a write commits at the following edge only if RAS/CAS still low.
  logic [7:0]  row_l;
  logic        pend;
  logic [13:0] paddr;
  logic [3:0]  pdata;
  initial begin
    pend = 1'b0;
    row_l = 8'h0;
    dram_dout = 4'h0;
    forever begin
      @(posedge clk);
      if (pend) begin
        if (!ras_n && !cas_n) dram[paddr] = pdata;
        pend = 1'b0;
      end
      if (!ras_n && cas_n) row_l = dram_addr;
      if (!ras_n && !cas_n && !wr_n) begin
        pend  = 1'b1;
        paddr = {dram_addr[6:1], row_l};
        pdata = dram_din;
      end
      if (!ras_n && !cas_n && !rd_n) dram_dout <= dram[{dram_addr[6:1], row_l}];
    end
  end

  // Transaction model: k counts cycles since the grant edge (0 = idle).
  // k=1 row, 2..4 column phase, 3 strobe, 5..4+PRE precharge, 5+PRE idle again.
  int          k;
  logic        m_vid, m_wr;
  logic [13:0] m_addr;
  logic [3:0]  m_din;
  logic        e_ras, e_cas, e_wr, e_rd, e_ack, e_valid, e_busy;
  logic [7:0]  e_addr;
  logic [3:0]  e_din, e_cdout, e_vdout;
  initial begin
    k = 0; m_vid = 0; m_wr = 0; m_addr = 0; m_din = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        k = 0;
        {e_ras, e_cas, e_wr, e_rd} = 4'hF;
        {e_ack, e_valid, e_busy} = 3'b000;
        e_addr = 8'h0; e_din = 4'h0; e_cdout = 4'h0; e_vdout = 4'h0;
      end else begin
        if (k == 0 || k == 5 + PRE) begin
          if (vid_req) begin
            k = 1; m_vid = 1; m_wr = 0; m_addr = vid_addr; m_din = 4'h0;
          end else if (cpu_req) begin
            k = 1; m_vid = 0; m_wr = cpu_wr; m_addr = cpu_addr; m_din = cpu_din;
          end else k = 0;
        end else k++;
        e_ras   = !(k >= 1 && k <= 4);
        e_cas   = !(k >= 2 && k <= 4);
        e_wr    = !(k == 3 && m_wr);
        e_rd    = !(k == 3 && !m_wr);
        e_ack   = (k == 5) && !m_vid;
        e_valid = (k == 5) && m_vid;
        e_busy  = (k >= 1 && k <= 4 + PRE);
        if (k == 1) e_addr = m_addr[7:0];
        else if (k >= 2 && k <= 4) e_addr = {1'b0, m_addr[13:8], 1'b0};
        if (k == 3) e_din = m_din;
        if (k == 5) begin
          if (m_wr)       gold[m_addr] = m_din;
          else if (m_vid) e_vdout = gold[m_addr];
          else            e_cdout = gold[m_addr];
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cycle_outputs",
            {cpu_ack, vid_valid, busy, ras_n, cas_n, wr_n, rd_n, dram_addr, dram_din, cpu_dout, vid_dout},
            {e_ack, e_valid, e_busy, e_ras, e_cas, e_wr, e_rd, e_addr, e_din, e_cdout, e_vdout});
      check("wr_rd_exclusive", wr_n | rd_n, 1);
      check("cas_without_ras", !(!cas_n && ras_n), 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  int ack_at, v_at, wr_low, n_ack, a1, a2;
  logic [7:0] row_a, col_a;
  logic vid_seen, busy12;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      dram[i] = init_val(14'(i));
      gold[i] = init_val(14'(i));
    end
    rst = 1; cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_din = 0; vid_req = 0; vid_addr = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'hF);
    check("reset_flags", {cpu_ack, vid_valid, busy}, 3'b000);
    check("reset_data", {dram_addr, dram_din, cpu_dout, vid_dout}, 20'h0);
    rst = 0;

    // 1: CPU write 2A5C <- 9
    cpu_wr = 1; cpu_addr = 14'h2A5C; cpu_din = 4'h9; cpu_req = 1;
    ack_at = -1; wr_low = 0; row_a = 0; col_a = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) row_a = dram_addr;
      if (i == 2) col_a = dram_addr;
      if (!wr_n) wr_low++;
      if (cpu_ack && ack_at < 0) begin ack_at = i; cpu_req = 0; end
    end
    check("t1_row_addr", row_a, 8'h5C);
    check("t1_col_addr", col_a, 8'h54);
    check("t1_wr_low_cycles", wr_low, 1);
    check("t1_ack_latency", ack_at - 1, 4);

    // 2: CPU read back 2A5C
    cpu_wr = 0; cpu_req = 1; ack_at = -1; vid_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (vid_valid) vid_seen = 1;
      if (cpu_ack && ack_at < 0) begin
        ack_at = i; cpu_req = 0;
        check("t2_read_data", cpu_dout, 4'h9);
      end
    end
    check("t2_ack_at", ack_at, 5);
    check("t2_no_valid", vid_seen, 0);

    // 3: video and CPU requests together
    vid_addr = 14'h0123; cpu_addr = 14'h2A5C; cpu_wr = 0;
    vid_req = 1; cpu_req = 1; v_at = -1; ack_at = -1; busy12 = 1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (vid_valid && v_at < 0) begin
        v_at = i; vid_req = 0;
        check("t3_vid_data", vid_dout, 4'h2);
      end
      if (cpu_ack && ack_at < 0) begin
        ack_at = i; cpu_req = 0;
        check("t3_cpu_data", cpu_dout, 4'h9);
      end
      if (i == 12) busy12 = busy;
    end
    check("t3_vid_first", v_at, 5);
    check("t3_cpu_second", ack_at, 11);
    check("t3_idle_after_12", busy12, 0);

    // 5: REQ held through ACK, top column boundary
    cpu_addr = 14'h3F0A; cpu_wr = 0; cpu_req = 1; n_ack = 0; a1 = -1; a2 = -1; col_a = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 2) col_a = dram_addr;
      if (cpu_ack) begin
        n_ack++;
        if (n_ack == 1) begin a1 = i; check("t5_read_data", cpu_dout, 4'h5); end
        if (n_ack == 2) begin a2 = i; cpu_req = 0; end
      end
    end
    check("t5_col_addr", col_a, 8'h7E);
    check("t5_period", a2 - a1, 6);

    // 4: reset during the strobe cycle of a write
    cpu_wr = 1; cpu_addr = 14'h1111; cpu_din = 4'hF; cpu_req = 1;
    repeat (3) @(negedge clk);
    check("t4_in_acc", wr_n, 0);
    rst = 1; cpu_req = 0;
    @(negedge clk);
    check("t4_strobes_idle", {ras_n, cas_n, wr_n, rd_n}, 4'hF);
    check("t4_no_ack", cpu_ack, 0);
    rst = 0;
    repeat (4) @(negedge clk);
    check("t4_mem_unchanged", dram[14'h1111], 4'h0);

    // 6: random traffic with the per-cycle checks running
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (cpu_req && cpu_ack) cpu_req = 0;
      else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1; cpu_wr = 1'($urandom_range(0, 1));
        cpu_addr = 14'($urandom); cpu_din = 4'($urandom);
      end
      if (vid_req && vid_valid) vid_req = 0;
      else if (!vid_req && $urandom_range(0, 5) == 0) begin
        vid_req = 1; vid_addr = 14'($urandom);
      end
    end
    for (int c = 0; c < 40 && (cpu_req || vid_req); c++) begin
      @(negedge clk);
      if (cpu_ack) cpu_req = 0;
      if (vid_valid) vid_req = 0;
    end
    check("t6_drained", {cpu_req, vid_req}, 2'b00);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
